// File: rtl/apb_or_accum_slave.sv
// rtl/apb_or_accum_slave.sv - APB3 completer with DATA/CONTROL/RESULT and a sticky OR accumulator
// Zero-wait-state; START in CONTROL ORs the stored DATA into RESULT and self-clears one edge later.
module apb_or_accum_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_DATA    = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_CONTROL = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RESULT  = ADDR_WIDTH'(8);

  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_start;

  logic w_access;
  logic w_sel_data;
  logic w_sel_control;
  logic w_sel_result;
  logic w_err;
  logic w_wr_data;
  logic w_wr_start;

  // Gating with PRESETn keeps the bus outputs quiet while reset is held.
  assign w_access      = PSEL & PENABLE & PRESETn;
  assign w_sel_data    = (PADDR == ADDR_DATA);
  assign w_sel_control = (PADDR == ADDR_CONTROL);
  assign w_sel_result  = (PADDR == ADDR_RESULT);

  assign w_err = w_access &
                 (~(w_sel_data | w_sel_control | w_sel_result) | (PWRITE & w_sel_result));

  assign w_wr_data  = w_access & PWRITE & ~w_err & w_sel_data;
  assign w_wr_start = w_access & PWRITE & ~w_err & w_sel_control & PWDATA[0];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_data   <= '0;
      r_result <= '0;
      r_start  <= 1'b0;
    end else begin
      r_start <= w_wr_start;
      if (w_wr_data) begin
        r_data <= PWDATA;
      end
      // Uses the DATA already stored; a same-cycle DATA write is impossible on APB.
      if (w_wr_start) begin
        r_result <= r_result | r_data;
      end
    end
  end

  always_comb begin
    PRDATA = '0;
    if (w_access && !PWRITE) begin
      if (w_sel_data) begin
        PRDATA = r_data;
      end else if (w_sel_control) begin
        PRDATA = DATA_WIDTH'(r_start);
      end else if (w_sel_result) begin
        PRDATA = r_result;
      end
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = w_err;

endmodule

// File: tb/tb_apb_or_accum_slave.sv
// tb/tb_apb_or_accum_slave.sv - scoreboard bench for apb_or_accum_slave
// Stimulus pushes expected responses; a negedge monitor pops them on every access phase.
module tb_apb_or_accum_slave;

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_or_accum_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .PSLVERR (PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_data   = 32'h0;
  logic [31:0] m_result = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: register file as plain variables; legality from the address map.
  function automatic exp_t model(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   legal;
    legal   = (a == 32'h0 || a == 32'h4 || a == 32'h8) && !(w && a == 32'h8);
    e.err   = !legal;
    e.rdata = 32'h0;
    if (legal) begin
      if (!w) begin
        if (a == 32'h0) e.rdata = m_data;
        else if (a == 32'h8) e.rdata = m_result;
      end else if (a == 32'h0) begin
        m_data = d;
      end else if (d[0]) begin
        m_result = m_result | m_data;
      end
    end
    return e;
  endfunction

  always @(negedge PCLK) begin
    if (PRESETn && PSEL && PENABLE) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_access addr=%h actual=none expected=queued", PADDR);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("prdata@%h", PADDR), PRDATA, mon_e.rdata);
        check($sformatf("pslverr@%h", PADDR), {31'b0, PSLVERR}, {31'b0, mon_e.err});
        check("pready", {31'b0, PREADY}, 32'h1);
      end
    end
  end

  // Called at #1 after a rising edge; leaves the bus in the access phase just past the commit edge.
  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
  endtask

  task automatic idle(input int n);
    PSEL = 1'b0; PENABLE = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge PCLK); #1;
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back(model(w, a, d));
    drive(w, a, d);
  endtask

  task automatic rd_exp(input logic [31:0] a, input logic [31:0] v, input logic err);
    exp_t e;
    e = model(1'b0, a, 32'h0);
    e.rdata = v;
    e.err   = err;
    exp_q.push_back(e);
    drive(1'b0, a, 32'h0);
  endtask

  task automatic accum(input logic [31:0] d, input logic [31:0] res);
    xfer(1'b1, 32'h0, d);
    xfer(1'b1, 32'h4, 32'h1);
    rd_exp(32'h8, res, 1'b0);
    idle(1);
  endtask

  initial begin
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = 32'h0; PWDATA = 32'h0;
    repeat (2) @(posedge PCLK);
    #1;
    check("reset_pready", {31'b0, PREADY}, 32'h1);
    check("reset_pslverr", {31'b0, PSLVERR}, 32'h0);
    check("reset_prdata", PRDATA, 32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    rd_exp(32'h0, 32'h0, 1'b0);
    rd_exp(32'h4, 32'h0, 1'b0);
    rd_exp(32'h8, 32'h0, 1'b0);
    idle(1);

    accum(32'h0000000C, 32'h0000000C);
    accum(32'h000000B0, 32'h000000BC);
    accum(32'h00000A00, 32'h00000ABC);
    rd_exp(32'h0, 32'h00000A00, 1'b0);
    rd_exp(32'h4, 32'h0, 1'b0);

    xfer(1'b1, 32'h0C, 32'h12345678);
    xfer(1'b1, 32'h10, 32'h12345678);
    xfer(1'b1, 32'h14, 32'hFFFFFFFF);
    xfer(1'b1, 32'h18, 32'h00000001);
    rd_exp(32'h10, 32'h0, 1'b1);
    rd_exp(32'h14, 32'h0, 1'b1);
    rd_exp(32'h18, 32'h0, 1'b1);
    xfer(1'b1, 32'h8, 32'hFFFFFFFF);
    rd_exp(32'h8, 32'h00000ABC, 1'b0);
    rd_exp(32'h0, 32'h00000A00, 1'b0);
    xfer(1'b1, 32'h4, 32'h00000000);
    rd_exp(32'h8, 32'h00000ABC, 1'b0);
    rd_exp(32'h4, 32'h0, 1'b0);
    idle(2);

    accum(32'h55555555, 32'h55555FFD);
    accum(32'hAAAAAAAA, 32'hFFFFFFFF);
    accum(32'hFFFFFFFF, 32'hFFFFFFFF);
    accum(32'h00000000, 32'hFFFFFFFF);
    rd_exp(32'h0, 32'h0, 1'b0);
    idle(1);

    // Reset mid-access of a DATA write, then observe quiet outputs during reset.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hDEADBEEF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    #2 PRESETn = 1'b0;
    m_data = 32'h0; m_result = 32'h0;
    #1;
    check("rst_mid_pslverr", {31'b0, PSLVERR}, 32'h0);
    check("rst_mid_pready", {31'b0, PREADY}, 32'h1);
    PWRITE = 1'b0; PADDR = 32'h10;
    #1;
    check("rst_inv_pslverr", {31'b0, PSLVERR}, 32'h0);
    check("rst_inv_prdata", PRDATA, 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    check("post_rst_idle_pslverr", {31'b0, PSLVERR}, 32'h0);
    rd_exp(32'h0, 32'h0, 1'b0);
    rd_exp(32'h4, 32'h0, 1'b0);
    rd_exp(32'h8, 32'h0, 1'b0);
    idle(1);

    for (int i = 0; i < 300; i++) begin
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      int          sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1:    a = 32'h0;
        2, 3:    a = 32'h4;
        4, 5:    a = 32'h8;
        6:       a = 32'h0C;
        7:       a = 32'h10 + 32'($urandom_range(0, 3)) * 4;
        8:       a = 32'($urandom_range(1, 11));
        default: a = $urandom;
      endcase
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      if ($urandom_range(0, 3) == 0) d = d & (32'h1 << $urandom_range(0, 31));
      xfer(w, a, d);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
